// File: rtl/fp_add_sched.sv
// fp_add_sched: round-robin scheduler sharing one pipelined fp32 adder between NREQ requesters.
//
// Operand pairs arrive on per-requester valid/ready handshakes; at most one pair per cycle is
// registered onto add_a/add_b. A tag pipe follows every issued op through the adder latency, and
// results land in issue order in a show-ahead FIFO, tagged with the issuing requester id. A
// credit counter (ops in flight + FIFO occupancy) keeps the FIFO from ever overflowing.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b          packed operands, requester i at bits [32i+31:32i]
//   resp_valid/ready     result FIFO head handshake
//   resp_data/resp_id    head result value and issuing requester
//   add_a/add_b          registered operands to the adder
//   add_out              adder result, LAT cycles after add_a/add_b
//   add_rst_n            ~rst, gates the adder output
//   busy                 any op in flight or any result queued
//
// Optional feature macro: FP_ADD_SCHED_ZERO_EN
//   The adder forces the hidden bit to 1 and so mis-adds zeros. When defined, operands with a
//   zero exponent field are detected at issue and the correct result travels in the tag pipe,
//   replacing add_out at FIFO write.
module fp_add_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [32*NREQ-1:0]       req_a,
  input  logic [32*NREQ-1:0]       req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_data,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic [31:0]              add_out,
  output logic                     add_rst_n,
  output logic                     busy
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Credits and round-robin grant
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  gnt_id;
  logic            gnt_any;
  logic            can_issue;
  logic            issue;
  logic            fifo_pop;
  int unsigned     idx;

  assign can_issue = !rst && (cnt_q < CntW'(DEPTH));

  // First valid requester at or after ptr_q, wrapping modulo NREQ.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[IdW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = IdW'(idx);
      end
    end
    if (can_issue && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign issue = can_issue && gnt_any;
  assign ptr_d = (gnt_id == IdW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, fifo_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ptr_q <= '0;
      add_a <= '0;
      add_b <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (issue) begin
        ptr_q <= ptr_d;
        add_a <= req_a[32*gnt_id +: 32];
        add_b <= req_b[32*gnt_id +: 32];
      end
    end
  end

  assign add_rst_n = ~rst;
  assign busy      = (cnt_q != '0);

  // ---------------------------------------------------------------------------
  // Tag pipe: stage 0 is loaded together with add_a/add_b, stage k lines up with adder stage k,
  // so stage LAT is valid in the cycle add_out carries that op's sum.
  // ---------------------------------------------------------------------------
  logic [LAT:0]          tag_vld_q;
  logic [LAT:0][IdW-1:0] tag_id_q;
  logic [31:0]           wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[LAT-1:0], issue};
      tag_id_q  <= {tag_id_q[LAT-1:0], gnt_id};
    end
  end

`ifdef FP_ADD_SCHED_ZERO_EN
  logic [LAT:0]       tag_ovr_q;
  logic [LAT:0][31:0] tag_val_q;
  logic [31:0]        op_a, op_b;
  logic               ovr;
  logic [31:0]        ovr_val;

  assign op_a = req_a[32*gnt_id +: 32];
  assign op_b = req_b[32*gnt_id +: 32];

  // A zero exponent field means the adder would treat the operand as 1.x * 2^-127.
  always_comb begin
    ovr     = 1'b0;
    ovr_val = '0;
    if (op_a[30:23] == 8'h00) begin
      ovr     = 1'b1;
      ovr_val = (op_a[30:0] == '0 && op_b[30:0] == '0) ? 32'h0000_0000 : op_b;
    end else if (op_b[30:23] == 8'h00) begin
      ovr     = 1'b1;
      ovr_val = op_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_ovr_q <= '0;
      tag_val_q <= '0;
    end else begin
      tag_ovr_q <= {tag_ovr_q[LAT-1:0], issue & ovr};
      tag_val_q <= {tag_val_q[LAT-1:0], ovr_val};
    end
  end

  assign wr_data = tag_ovr_q[LAT] ? tag_val_q[LAT] : add_out;
`else
  assign wr_data = add_out;
`endif

  // ---------------------------------------------------------------------------
  // Result FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [31:0]     fifo_data_q [DEPTH];
  logic [IdW-1:0]  fifo_id_q   [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fill_q, fill_d;
  logic            fifo_wr;

  assign fifo_wr    = tag_vld_q[LAT];
  assign resp_valid = (fill_q != '0);
  assign fifo_pop   = resp_valid & resp_ready;
  // Storage is not reset; gate the head so an empty FIFO presents zeros.
  assign resp_data  = resp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_id    = resp_valid ? fifo_id_q[rd_ptr_q] : '0;

  always_comb begin
    fill_d = fill_q;
    unique case ({fifo_wr, fifo_pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      fill_q <= fill_d;
      if (fifo_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data_q[wr_ptr_q] <= wr_data;
      fifo_id_q[wr_ptr_q]   <= tag_id_q[LAT];
    end
  end

  // Credits bound FIFO occupancy, so a write into a full FIFO without a pop cannot happen.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (fifo_wr && !fifo_pop) |-> (fill_q != CntW'(DEPTH)));

endmodule
